// File: rtl/matrix_scan_ctrl_pkg.sv
// Shared definitions for the row-scan controller: FSM state encoding and width helper.
package matrix_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DRIVE
    } scan_state_t;

    // Bits needed to index n items, never less than one.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/matrix_scan_ctrl_slot_timer.sv
// Slot cycle counter: cleared at slot start, flags the end of blanking and end of slot.
module slot_timer
    import matrix_scan_ctrl_pkg::*;
#(
    parameter int unsigned SLOT  = 1000,
    parameter int unsigned BLANK = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic blank_done,
    output logic slot_done
);

    localparam int unsigned CW = idx_width(SLOT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign blank_done = (cnt == CW'(BLANK - 1));
    assign slot_done  = (cnt == CW'(SLOT - 1));

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row-scan controller for a multiplexed matrix: blank, then drive one row per slot.
module matrix_scan_ctrl
    import matrix_scan_ctrl_pkg::*;
#(
    parameter int unsigned ROWS    = 8,
    parameter int unsigned SLOT    = 1000,
    parameter int unsigned BLANK   = 2,
    parameter int unsigned ACT_LOW = 0,
    localparam int unsigned IDX_W  = idx_width(ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    output logic [IDX_W-1:0] idx,
    output logic [ROWS-1:0]  row,
    output logic             blank,
    output logic             frame_start
);

    localparam logic [ROWS-1:0] ROW_OFF = (ACT_LOW != 0) ? {ROWS{1'b1}} : {ROWS{1'b0}};

    scan_state_t      state, state_nx;
    logic [IDX_W-1:0] idx_nx;
    logic [ROWS-1:0]  row_nx;
    logic             clear, blank_done, slot_done;

    slot_timer #(
        .SLOT  (SLOT),
        .BLANK (BLANK)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .blank_done (blank_done),
        .slot_done  (slot_done)
    );

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        clear    = 1'b0;
        unique case (state)
            S_IDLE: begin
                clear = 1'b1;
                if (en) state_nx = S_BLANK;
            end
            S_BLANK: begin
                if (!en) begin
                    state_nx = S_IDLE;
                    clear    = 1'b1;
                end else if (blank_done) begin
                    state_nx = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (!en) begin
                    state_nx = S_IDLE;
                    clear    = 1'b1;
                end else if (slot_done) begin
                    state_nx = S_BLANK;
                    clear    = 1'b1;
                    if (dir) idx_nx = (idx == '0) ? IDX_W'(ROWS - 1) : idx - 1'b1;
                    else     idx_nx = (idx == IDX_W'(ROWS - 1)) ? '0 : idx + 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                clear    = 1'b1;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        row_nx = ROW_OFF;
        if (state_nx == S_DRIVE) begin
            for (int unsigned i = 0; i < ROWS; i++) begin
                if (idx_nx == IDX_W'(ROWS - 1 - i)) row_nx[i] = ~ROW_OFF[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            row         <= ROW_OFF;
            blank       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            row         <= row_nx;
            blank       <= (state_nx != S_DRIVE);
            frame_start <= (state_nx == S_BLANK) && (state != S_BLANK) && (idx_nx == '0);
        end
    end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench: slot scoreboard on the 8-row instance, direct checks on a 5-row active-low instance.
module tb_matrix_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset, en, dir;
    logic [2:0] idx;
    logic [7:0] row;
    logic       blank, frame_start;

    logic       reset_b, en_b, dir_b;
    logic [2:0] idx_b;
    logic [4:0] row_b;
    logic       blank_b, frame_start_b;

    int unsigned n_eval = 0;
    int unsigned n_fail = 0;

    typedef struct {
        int unsigned idx;
        int unsigned row;
        int unsigned nb;
        int unsigned nd;
        int unsigned nfs;
    } slot_t;

    slot_t       sb[$];
    int unsigned pops = 0;
    logic        mon_en = 1'b0;
    logic        chk_on = 1'b0;

    always #5 clk = ~clk;

    matrix_scan_ctrl #(
        .ROWS    (8),
        .SLOT    (10),
        .BLANK   (2),
        .ACT_LOW (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .dir         (dir),
        .idx         (idx),
        .row         (row),
        .blank       (blank),
        .frame_start (frame_start)
    );

    matrix_scan_ctrl #(
        .ROWS    (5),
        .SLOT    (10),
        .BLANK   (2),
        .ACT_LOW (1)
    ) dut_b (
        .clk         (clk),
        .reset       (reset_b),
        .en          (en_b),
        .dir         (dir_b),
        .idx         (idx_b),
        .row         (row_b),
        .blank       (blank_b),
        .frame_start (frame_start_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_slot(input int unsigned i);
        slot_t s;
        s.idx = i;
        s.row = 32'h80 >> i;
        s.nb  = 2;
        s.nd  = 8;
        s.nfs = (i == 0) ? 1 : 0;
        sb.push_back(s);
    endtask

    task automatic wait_pops(input int unsigned target);
        int unsigned n;
        n = 0;
        while (pops < target && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("pops_reached", pops, target);
    endtask

    // Slot monitor: measures each completed blank+drive slot and compares it with the queue.
    int unsigned nb, nd, nfs, glitch;
    logic [2:0]  s_idx;
    logic [7:0]  s_row;
    logic        prev_blank;
    slot_t       got;

    always @(negedge clk) begin
        if (!mon_en) begin
            nb = 0; nd = 0; nfs = 0; glitch = 0; prev_blank = 1'b1;
        end else begin
            if (blank) begin
                if (!prev_blank) begin
                    chk("sb_has_entry", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        got = sb.pop_front();
                        chk("slot_idx", s_idx, got.idx);
                        chk("slot_row", s_row, got.row);
                        chk("slot_blank_len", nb, got.nb);
                        chk("slot_drive_len", nd, got.nd);
                        chk("slot_frame_start", nfs, got.nfs);
                        chk("slot_drive_stable", glitch, 0);
                    end
                    pops++;
                    nb = 0; nd = 0; nfs = 0; glitch = 0;
                end
                nb++;
            end else begin
                if (prev_blank) begin
                    s_idx = idx;
                    s_row = row;
                end else if (row !== s_row || idx !== s_idx) begin
                    glitch++;
                end
                nd++;
            end
            nfs += frame_start;
            prev_blank = blank;
        end
    end

    // Structural invariants on both instances every cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("a_blank_iff_off", blank, row == 8'h00);
            chk("a_row_onehot", $countones(row) <= 1, 1);
            chk("b_blank_iff_off", blank_b, row_b == 5'h1f);
            chk("b_row_onecold", $countones(~row_b) <= 1, 1);
            chk("b_idx_range", idx_b < 3'd5, 1);
        end
    end

    initial begin
        reset = 1'b1; en = 1'b0; dir = 1'b0;
        reset_b = 1'b1; en_b = 1'b0; dir_b = 1'b0;

        @(negedge clk);
        chk("rst_idx", idx, 0);
        chk("rst_row", row, 8'h00);
        chk("rst_blank", blank, 1);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_b_row", row_b, 5'h1f);
        chk_on = 1'b1;
        #1 reset = 1'b0; en = 1'b1;

        // First BLANK arrives on the first edge after release, carrying frame_start.
        @(posedge clk); #1;
        chk("first_fs", frame_start, 1);
        chk("first_blank", blank, 1);
        chk("first_idx", idx, 0);
        for (int unsigned i = 0; i < 8; i++) push_slot(i);
        push_slot(0);
        mon_en = 1'b1;
        wait_pops(9);

        push_slot(1); push_slot(2);
        wait_pops(11);
        push_slot(3);
        repeat (5) @(negedge clk);
        #1 dir = 1'b1;
        push_slot(2); push_slot(1); push_slot(0); push_slot(7);
        wait_pops(16);
        push_slot(6);
        wait_pops(17);

        // Drop enable in the middle of the idx=5 drive phase.
        repeat (4) @(negedge clk);
        #1;
        chk("pre_drop_row", row, 8'h04);
        chk("pre_drop_idx", idx, 5);
        chk("pre_drop_blank", blank, 0);
        mon_en = 1'b0;
        en = 1'b0;
        @(negedge clk);
        chk("drop_row", row, 8'h00);
        chk("drop_blank", blank, 1);
        chk("drop_idx", idx, 5);
        repeat (2) @(negedge clk);
        #1 en = 1'b1;
        for (int unsigned c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("resume_idx", idx, 5);
            chk("resume_blank", blank, c < 2);
            chk("resume_row", row, (c < 2) ? 8'h00 : 8'h04);
        end
        @(negedge clk);
        chk("resume_next_idx", idx, 4);
        chk("resume_next_blank", blank, 1);

        #1 dir = 1'b0;
        repeat (24) @(negedge clk);
        #1;
        chk("pre_rst_row", row, 8'h02);
        chk("pre_rst_idx", idx, 6);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_row", row, 8'h00);
        chk("async_rst_idx", idx, 0);
        chk("async_rst_blank", blank, 1);
        chk("async_rst_fs", frame_start, 0);
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_fs", frame_start, 1);
        chk("post_rst_blank", blank, 1);
        chk("post_rst_row", row, 8'h00);
        push_slot(0); push_slot(1); push_slot(2);
        mon_en = 1'b1;
        wait_pops(20);
        mon_en = 1'b0;
        chk("sb_drained", sb.size(), 0);

        // Five-row active-low instance: idle level, then twelve slots across two wraps.
        @(negedge clk);
        #1 reset_b = 1'b0;
        @(negedge clk);
        chk("b_idle_row", row_b, 5'h1f);
        chk("b_idle_blank", blank_b, 1);
        chk("b_idle_idx", idx_b, 0);
        chk("b_idle_fs", frame_start_b, 0);
        #1 en_b = 1'b1;
        for (int unsigned s = 0; s < 12; s++) begin
            for (int unsigned c = 0; c < 10; c++) begin
                @(negedge clk);
                chk("b_idx", idx_b, s % 5);
                chk("b_blank", blank_b, c < 2);
                chk("b_row", row_b, (c < 2) ? 5'h1f : (~(5'h10 >> (s % 5)) & 5'h1f));
                chk("b_fs", frame_start_b, (c == 0) && (s % 5 == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
